// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//
// Pipeline hazard controller for a classic 5-stage in-order core. It decides,
// every cycle, whether to freeze the front end, inject a bubble into the
// decode/execute register, or squash the fetch/decode register. It also keeps
// two saturating performance counters.
//
// Hazard outputs are combinational in the current state and inputs, so the
// pipe reacts in the same cycle as the event. Priority is:
// memory busy, then taken branch, then load-use.
//
// Ports
//   clk            in   1  rising-edge clock
//   rstn           in   1  asynchronous active-low reset
//   idex_MemRead   in   1  decode/execute register holds a load
//   idex_rd        in   5  destination register of that instruction
//   ifid_rs1       in   5  rs1 of the instruction in decode
//   ifid_rs2       in   5  rs2 of the instruction in decode
//   ifid_uses_rs2  in   1  decode instruction reads rs2 (R, S, B type)
//   branch_taken   in   1  EX resolved a taken branch this cycle
//   mem_busy       in   1  data memory not ready; freeze the whole pipe
//   clr_counters   in   1  synchronous clear of both counters
//   pc_stall       out  1  hold the PC
//   ifid_stall     out  1  hold fetch/decode
//   idex_stall     out  1  hold decode/execute
//   idex_bubble    out  1  zero decode/execute control fields on next edge
//   ifid_flush     out  1  replace fetch/decode with a NOP on next edge
//   stall_cycles   out 16  cycles with pc_stall=1 (saturating)
//   flush_count    out 16  accepted branch flushes (saturating)
// -----------------------------------------------------------------------------
module hazard_control_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic        idex_MemRead,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        ifid_uses_rs2,
  input  logic        branch_taken,
  input  logic        mem_busy,
  input  logic        clr_counters,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  // RUN       : normal flow
  // LU_BUBBLE : a load-use bubble was just injected; the load has moved on,
  //             so a repeat of the same comparison must not stall again
  // BR_FLUSH  : EX holds the bubble from a flush; its branch_taken is stale
  // MEM_WAIT  : the pipe was frozen last cycle; behaves exactly like RUN
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    BR_FLUSH  = 2'd2,
    MEM_WAIT  = 2'd3
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t state;
  state_t state_next;

  logic lu_hz;
  logic pc_stall_c;
  logic ifid_stall_c;
  logic idex_stall_c;
  logic idex_bubble_c;
  logic ifid_flush_c;

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign lu_hz = idex_MemRead && (idex_rd != 5'd0) &&
                 ((idex_rd == ifid_rs1) ||
                  (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  // NOTE: state and counters use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next    = RUN;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    idex_stall_c  = 1'b0;
    idex_bubble_c = 1'b0;
    ifid_flush_c  = 1'b0;

    if (mem_busy) begin
      pc_stall_c   = 1'b1;
      ifid_stall_c = 1'b1;
      idex_stall_c = 1'b1;
      state_next   = MEM_WAIT;
    end else begin
      unique case (state)
        RUN, MEM_WAIT: begin
          if (branch_taken) begin
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
            state_next    = BR_FLUSH;
          end else if (lu_hz) begin
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_bubble_c = 1'b1;
            state_next    = LU_BUBBLE;
          end
        end
        LU_BUBBLE: begin
          // The load already advanced past EX; only a branch matters here.
          if (branch_taken) begin
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
            state_next    = BR_FLUSH;
          end
        end
        BR_FLUSH: begin
          // EX holds the injected bubble; its branch and hazard inputs are
          // meaningless this cycle.
          state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  // Outputs are forced low while reset is held, whatever the inputs do.
  assign pc_stall    = rstn & pc_stall_c;
  assign ifid_stall  = rstn & ifid_stall_c;
  assign idex_stall  = rstn & idex_stall_c;
  assign idex_bubble = rstn & idex_bubble_c;
  assign ifid_flush  = rstn & ifid_flush_c;

  // Performance counters: clear wins over increment; both saturate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else if (clr_counters) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      if (pc_stall && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (ifid_flush && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end

endmodule
